// File: rtl/k2red_mul_iter.sv
// Iterative W x W unsigned multiplier feeding the K2-RED reducer: one DIGIT_W-bit digit
// of Y per cycle, LSD first, with the Q/k1/k2/m sideband carried alongside the product.
`timescale 1ns/1ps

module k2red_mul_iter #(
    parameter int W       = 64,
    parameter int DIGIT_W = 16,   // W must be a multiple of DIGIT_W
    parameter int PW      = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      X,
    input  logic [W-1:0]      Y,
    input  logic [W-1:0]      Q_in,
    input  logic [PW-1:0]     k1_in,
    input  logic [PW-1:0]     k2_in,
    input  logic [PW-1:0]     m_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    A,
    output logic [W-1:0]      Q,
    output logic [PW-1:0]     k1,
    output logic [PW-1:0]     k2,
    output logic [PW-1:0]     m
);

    localparam int ND  = W / DIGIT_W;
    localparam int CW  = (ND > 1) ? $clog2(ND) : 1;
    localparam int AW  = 2 * W;
    localparam int PPW = W + DIGIT_W;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [W-1:0]        x_q, y_q, qs_q;
    logic [PW-1:0]       k1s_q, k2s_q, ms_q;
    logic [AW-1:0]       acc_q;
    logic                out_valid_q;
    logic [AW-1:0]       a_q;
    logic [W-1:0]        q_q;
    logic [PW-1:0]       k1_q, k2_q, m_q;

    int unsigned         sh;
    logic [DIGIT_W-1:0]  digit;
    logic [PPW-1:0]      pp;
    logic [AW-1:0]       acc_d;

    // Partial product of X and the current Y digit, placed at its digit weight.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sh    = 0;
        digit = '0;
        pp    = '0;
        acc_d = acc_q;
        sh    = int'(cnt_q) * DIGIT_W;
        digit = DIGIT_W'(y_q >> sh);
        pp    = PPW'(x_q) * PPW'(digit);
        acc_d = acc_q + (AW'(pp) << sh);
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            qs_q        <= '0;
            k1s_q       <= '0;
            k2s_q       <= '0;
            ms_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            q_q         <= '0;
            k1_q        <= '0;
            k2_q        <= '0;
            m_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= X;
                        y_q     <= Y;
                        qs_q    <= Q_in;
                        k1s_q   <= k1_in;
                        k2s_q   <= k2_in;
                        ms_q    <= m_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    // Final digit: publish product and sideband together.
                    if (cnt_q == CW'(ND - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        a_q         <= acc_d;
                        q_q         <= qs_q;
                        k1_q        <= k1s_q;
                        k2_q        <= k2s_q;
                        m_q         <= ms_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign A         = a_q;
    assign Q         = q_q;
    assign k1        = k1_q;
    assign k2        = k2_q;
    assign m         = m_q;

endmodule
